// File: rtl/pipeline_adder_arbiter_pkg.sv
// Shared constants and helpers for the arbitrated, pipelined adder.
package pipeline_adder_pkg;

    localparam int W_DEFAULT   = 64;
    localparam int N_DEFAULT   = 4;
    localparam int LAT_DEFAULT = 3;
    localparam int CS_BLK      = 8;

    // Round-robin successor of the granted requester g among n requesters.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 32'd1 >= n) ? 32'd0 : g + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_adder_arbiter_if.sv
// Request/response bundle between client engines and the shared adder block.
interface pipeline_adder_arbiter_if #(
    parameter int W   = 64,
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) ();
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           busy;

    modport master (
        output req_valid, req_a, req_b, req_cin,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/pipeline_carry_skip_adder.sv
// LAT-deep pipelined W-bit carry-skip adder; the datapath is deliberately not reset.
module pipeline_carry_skip_adder
    import pipeline_adder_pkg::*;
#(
    parameter int W   = 64,
    parameter int LAT = 3
) (
    input  logic         clk,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Ripple inside CS_BLK-bit blocks; a fully propagating block forwards its carry-in.
    function automatic logic [W:0] cs_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c_in);
        logic [W-1:0] s;
        logic         c;
        logic         cb;
        logic         p_all;
        logic         p;
        s = '0;
        c = c_in;
        for (int base = 0; base < W; base += CS_BLK) begin
            cb    = c;
            p_all = 1'b1;
            for (int j = 0; j < CS_BLK; j++) begin
                if (base + j < W) begin
                    p           = x[base+j] ^ y[base+j];
                    s[base+j]   = p ^ c;
                    c           = (x[base+j] & y[base+j]) | (p & c);
                    p_all       = p_all & p;
                end
            end
            c = p_all ? cb : c;
        end
        return {c, s};
    endfunction

    logic [W:0] stage_q [LAT];

    // Add in the first stage, then delay the result to the full pipeline depth.
    always_ff @(posedge clk) begin
        stage_q[0] <= cs_add(a, b, cin);
        for (int s = 1; s < LAT; s++) begin
            stage_q[s] <= stage_q[s-1];
        end
    end

    assign {cout, sum} = stage_q[LAT-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module rr_arbiter
    import pipeline_adder_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_any
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [N-1:0]   rot_s;
    logic [IDW-1:0] off_s;
    logic [IDW:0]   pos_s;

    // Rotate requests so the pointer sits at bit 0, find the nearest one, map back.
    always_comb begin
        rot_s   = N'({req, req} >> ptr_q);
        off_s   = '0;
        gnt_any = |rot_s;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = IDW'(k);
            end else begin
                off_s = off_s;
            end
        end
        pos_s = {1'b0, ptr_q} + {1'b0, off_s};
        if (pos_s >= (IDW+1)'(N)) begin
            gnt_id = IDW'(pos_s - (IDW+1)'(N));
        end else begin
            gnt_id = IDW'(pos_s);
        end
        for (int i = 0; i < N; i++) begin
            gnt[i] = gnt_any && (gnt_id == IDW'(i));
        end
    end

    // Next pointer is the requester after the winner; idle cycles hold it.
    always_comb begin
        if (gnt_any) begin
            ptr_d = IDW'(rr_next(32'(gnt_id), N));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pipeline_adder_arbiter.sv
// N clients share one pipelined adder; an ID tag pipe routes each sum back to its owner.
module pipeline_adder_arbiter
    import pipeline_adder_pkg::*;
#(
    parameter int W   = W_DEFAULT,
    parameter int N   = N_DEFAULT,
    parameter int LAT = LAT_DEFAULT,
    parameter int IDW = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    pipeline_adder_arbiter_if.slave  bus
);

    logic [N-1:0]   gnt_s;
    logic [IDW-1:0] gnt_id_s;
    logic           gnt_any_s;
    logic [W-1:0]   add_a_s;
    logic [W-1:0]   add_b_s;
    logic           add_cin_s;
    logic [W-1:0]   add_sum_s;
    logic           add_cout_s;

    logic [LAT-1:0] tag_vld_q;
    logic [IDW-1:0] tag_id_q [LAT];
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_sum_q;
    logic           rsp_cout_q;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .gnt     (gnt_s),
        .gnt_id  (gnt_id_s),
        .gnt_any (gnt_any_s)
    );

    // AND-OR operand mux; zeros reach the adder when nothing is granted.
    always_comb begin
        add_a_s   = '0;
        add_b_s   = '0;
        add_cin_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            add_a_s   = add_a_s | (bus.req_a[i*W +: W] & {W{gnt_s[i]}});
            add_b_s   = add_b_s | (bus.req_b[i*W +: W] & {W{gnt_s[i]}});
            add_cin_s = add_cin_s | (bus.req_cin[i] & gnt_s[i]);
        end
    end

    pipeline_carry_skip_adder #(.W(W), .LAT(LAT)) u_add (
        .clk  (clk),
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (add_cin_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Tag pipe mirrors the adder depth; reset drops in-flight tags so stale sums are masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_vld_q[0] <= gnt_any_s;
            tag_id_q[0]  <= gnt_id_s;
            for (int s = 1; s < LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    // Response register; sum/carry hold unless a tagged result is retiring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            rsp_valid_q <= tag_vld_q[LAT-1];
            rsp_id_q    <= tag_id_q[LAT-1];
            if (tag_vld_q[LAT-1]) begin
                rsp_sum_q  <= add_sum_s;
                rsp_cout_q <= add_cout_s;
            end
        end
    end

    assign bus.req_ready = gnt_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.busy      = (|tag_vld_q) | rsp_valid_q;

endmodule

// File: doc/pipeline_adder_arbiter.md
# pipeline_adder_arbiter

Shares one pipelined carry-skip adder among N independent requesters. Each cycle a round-robin arbiter accepts at most one operand pair. The pair is issued to the adder, and a requester-ID tag travels alongside it through a matching tag pipeline. When the sum emerges, it is routed back through a registered response port. The block sits between the adder datapath and the client engines that previously each needed a private adder.

## Interface
- `W`, 64: operand/sum width
- `N`, 4: number of requesters (2..16)
- `LAT`, 3: adder pipeline depth, in cycles from operand sample edge to valid `sum`/`cout`; must equal the instantiated adder's depth
- `IDW`, `$clog2(N)`: requester ID width (derived)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in N: requester i has an operation pending
- `req_ready` out N: one-hot grant; an op is accepted on a cycle with `req_valid[i] && req_ready[i]`
- `req_a` in N*W: operand A, slice i = `[i*W +: W]`
- `req_b` in N*W: operand B, same slicing
- `req_cin` in N: carry-in per requester
- `rsp_valid` out 1: one-cycle pulse, response present
- `rsp_id` out IDW: requester that owns the response
- `rsp_sum` out W: `a + b + cin`, modulo 2^W
- `rsp_cout` out 1: carry-out of the W-bit add
- `busy` out 1: at least one op is in flight, or a response is being presented

## Operation
- **Arbitration:** round-robin with pointer `ptr`. Search order is `ptr, ptr+1, …, N-1, 0, …`; the first requester with `req_valid` high is granted.
- **Grant output:** `req_ready` is combinational from `req_valid` and `ptr`. At most one bit is set, and it is zero when no request is pending.
- **Pointer update:** on an accepted grant to requester g, `ptr <= (g+1) mod N`. With no grant, `ptr` holds.
- **Issue:** the granted `a`, `b`, `cin` are muxed combinationally onto the adder inputs. Non-grant cycles drive zeros.
- **Tag pipe:** `LAT` stages of `{vld, id}`. Stage 0 loads `{grant_any, g}`; every stage shifts every cycle. There is no stall, and the adder is fully pipelined.
- **Response stage:** register `{rsp_valid, rsp_id, rsp_sum, rsp_cout} <= {tag[LAT-1].vld, tag[LAT-1].id, adder.sum, adder.cout}`.
  - `rsp_sum` and `rsp_cout` update only when `tag[LAT-1].vld` is set; otherwise they hold.
- **No backpressure on responses:** clients must accept `rsp_valid` unconditionally.
- **Busy:** `busy = |tag_vld | rsp_valid`, registered-source combinational OR.
- **Arithmetic:** full W-bit add with carry-in. Overflow wraps; `rsp_cout` reports the carry.
  - Example: `a = 2^64-1`, `b = 0`, `cin = 1` gives `sum = 0`, `cout = 1`.

## Timing
- **Reset values:**
  - `ptr = 0` (requester 0 has top priority)
  - all tag `vld = 0`
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_sum = 0`, `rsp_cout = 0`, `busy = 0`
  - `req_ready` follows `req_valid` immediately after reset
- **Latency:** an op accepted at edge k produces `rsp_valid` high during cycle k+LAT+1. That is LAT+1 cycles, fixed.
- **Throughput:** one op per cycle sustained. Responses return in issue order, one per cycle at most.
- **Fairness:** with all N requesters held valid, grants rotate `0,1,…,N-1,0…`. No requester waits more than N-1 cycles.
- **Back-to-back:** a single requester held valid alone is granted every cycle.
- **Reset mid-operation:** all in-flight tags are dropped and no response is emitted for them. The adder's data pipeline is not reset; the dropped tags mask its garbage output.
- **Simultaneous issue and retire:** independent; no interaction.

## Structure
- **Shared package `pipeline_adder_pkg`:**
  - `W` default
  - tag struct/width `{vld, id}`
  - `rr_next(ptr, g)` helper constant function, if the flow permits
- **Sub-module `rr_arbiter`:** parameter N; inputs `clk`, `rst`, `req[N]`; outputs `gnt[N]` (one-hot), `gnt_id`, `gnt_any`; pointer held inside.
- **Top:** instantiates `rr_arbiter`, the operand mux, the existing `pipeline_carry_skip_adder` (ports `a`, `b`, `cin`, `sum`, `cout`, `clk`), the LAT-deep tag shift register, and the response register.

## Test plan
1. **Reset:** hold `rst` for 3 cycles with random `req_valid`. All outputs read 0 and `ptr = 0`. Release `rst` with `req_valid = 4'b0110`: `req_ready = 4'b0010`.
2. **Single op:** requester 2 sends `a = 200`, `b = 5`, `cin = 1`. LAT+1 cycles after acceptance: `rsp_valid = 1`, `rsp_id = 2`, `rsp_sum = 206`, `rsp_cout = 0`. `busy` drops the following cycle.
3. **Wrap/carry:** `a = 64'hFFFF_FFFF_FFFF_FFFF`, `b = 0`, `cin = 1` gives `rsp_sum = 0`, `rsp_cout = 1`. Also `a = b = 2^63` with `cin = 0` gives `rsp_sum = 0`, `rsp_cout = 1`.
4. **Fairness:** all 4 requesters valid for 12 cycles, each with `a = id`, `b = 100`. Grant order is `0,1,2,3` repeated three times, and responses return in the same order with `rsp_sum = 100 + id`.
5. **Streaming:** requester 0 alone is valid for 200 cycles with incrementing `a`/`b` (`a = n`, `b = 200 + n`). This gives 200 consecutive `rsp_valid` pulses with `sum = 200 + 2n`, no gaps.
6. **Reset mid-flight:** issue 3 ops, then assert `rst` for 1 cycle before any response. No `rsp_valid` appears afterwards, and the first post-reset op returns correctly with `rsp_id` of its owner.
